// File: rtl/irq_pkg.sv
// Shared types and constants for the external-interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] ADDR_ENABLE = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

endpackage

// File: rtl/irq_controller_if.sv
// Bundles interrupt sources, the register port and the core-side ExtIRQ handshake.
interface irq_controller_if #(
  parameter int NCH = 8,
  parameter int N   = 64,
  parameter int IW  = $clog2(NCH)
);
  logic [NCH-1:0] irq_in;
  logic           cfg_we;
  logic [1:0]     cfg_addr;
  logic [N-1:0]   cfg_wdata;
  logic [N-1:0]   cfg_rdata;
  logic           ExtIRQ;
  logic           ExtIAck;
  logic           eoi;
  logic [IW-1:0]  irq_id;

  modport master (
    output irq_in, cfg_we, cfg_addr, cfg_wdata, ExtIAck, eoi,
    input  cfg_rdata, ExtIRQ, irq_id
  );

  modport slave (
    input  irq_in, cfg_we, cfg_addr, cfg_wdata, ExtIAck, eoi,
    output cfg_rdata, ExtIRQ, irq_id
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: first set bit of req searching upward from
// start, wrapping modulo NCH.
module irq_prio_enc #(
  parameter int NCH = 8,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  start,
  output logic           valid,
  output logic [IW-1:0]  winner
);

  logic [IW:0] idx;

  // Walk the search order backwards so the earliest hit is the last one written.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = {1'b0, start} + (IW+1)'(k);
      if (idx >= (IW+1)'(NCH)) idx = idx - (IW+1)'(NCH);
      if (req[idx[IW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// External-interrupt controller: edge/level capture, fixed or rotating
// arbitration, and a one-at-a-time request/ack/eoi handshake to the core.
//   state   | meaning
//   IDLE    | no request outstanding; arbitrate pending & enabled channels
//   REQ     | ExtIRQ high for irq_id, waiting for ExtIAck
//   SERVICE | core is running the handler, waiting for eoi
module irq_controller
  import irq_pkg::*;
#(
  parameter int NCH = 8,
  parameter int N   = 64,
  parameter int IW  = $clog2(NCH)
) (
  input logic             clk,
  input logic             reset,
  irq_controller_if.slave bus
);

  irq_state_t     state, state_next;
  logic [NCH-1:0] enable, mode, pend_edge, irq_q;
  logic [NCH-1:0] pend, cand, ack_clr, w1c, pend_edge_next;
  logic           rotate;
  logic [IW-1:0]  last, irq_id_r, start, win_id;
  logic           win_valid, latch, ack_take;

  // Level channels mirror the registered input; edge channels use the sticky bits.
  assign pend  = (mode & pend_edge) | (~mode & irq_q);
  assign cand  = pend & enable;
  assign start = !rotate ? '0 : (last == IW'(NCH-1)) ? '0 : last + IW'(1);

  irq_prio_enc #(.NCH(NCH), .IW(IW)) u_prio (
    .req    (cand),
    .start  (start),
    .valid  (win_valid),
    .winner (win_id)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: if (win_valid) begin
        state_next = REQ;
        latch      = 1'b1;
      end
      REQ: if (bus.ExtIAck) begin
        state_next = SERVICE;
        ack_take   = 1'b1;
      end
      SERVICE: if (bus.eoi) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ack_clr = ack_take ? (NCH'(1) << irq_id_r) : '0;
  assign w1c     = (bus.cfg_we && bus.cfg_addr == ADDR_PEND) ? bus.cfg_wdata[NCH-1:0] : '0;
  // A new edge in the same cycle as a clear wins.
  assign pend_edge_next = ((pend_edge & ~(ack_clr | w1c)) | (bus.irq_in & ~irq_q)) & mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable    <= '0;
      mode      <= '0;
      pend_edge <= '0;
      irq_q     <= '0;
      rotate    <= 1'b0;
      last      <= IW'(NCH-1);
      irq_id_r  <= '0;
    end else begin
      irq_q     <= bus.irq_in;
      pend_edge <= pend_edge_next;
      if (latch)    irq_id_r <= win_id;
      if (ack_take) last     <= irq_id_r;
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          ADDR_ENABLE: enable <= bus.cfg_wdata[NCH-1:0];
          ADDR_MODE:   mode   <= bus.cfg_wdata[NCH-1:0];
          ADDR_CTRL:   rotate <= bus.cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      ADDR_ENABLE: bus.cfg_rdata[NCH-1:0]  = enable;
      ADDR_MODE:   bus.cfg_rdata[NCH-1:0]  = mode;
      ADDR_PEND:   bus.cfg_rdata[NCH-1:0]  = pend;
      default:     bus.cfg_rdata[IW+2:0]   = {state, rotate, irq_id_r};
    endcase
  end

  assign bus.ExtIRQ = (state == REQ);
  assign bus.irq_id = irq_id_r;

  // Write-data bits above the channel count carry no state.
  if (N > NCH) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.cfg_wdata[N-1:NCH];
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register vector table, directed
// handshake sequences, and randomized traffic against a reference model.
module tb_irq_controller;
  localparam int NCH = 8;
  localparam int N   = 64;
  localparam int IW  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_controller_if #(.NCH(NCH), .N(N)) bus();
  irq_controller #(.NCH(NCH), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[6];

  // reference model state
  logic [7:0] m_en, m_mode, m_pe, m_q;
  bit         m_rot;
  int         m_phase;   // 0 waiting, 1 requesting, 2 in handler
  int         m_id, m_last;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [63:0] exp);
    bus.cfg_addr = a;
    #1;
    chk(name, bus.cfg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic ack();
    bus.ExtIAck = 1'b1; step(); bus.ExtIAck = 1'b0;
  endtask

  task automatic eoi_p();
    bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    bus.irq_in = v; step(); bus.irq_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic chk_req(input string name, input logic on, input int id);
    chk({name, "_extirq"}, 64'(bus.ExtIRQ), 64'(on));
    if (on) chk({name, "_id"}, 64'(bus.irq_id), 64'(id));
  endtask

  function automatic int pick(input logic [7:0] c, input int start);
    for (int k = 0; k < 8; k++)
      if (c[3'((start + k) % 8)]) return (start + k) % 8;
    return 0;
  endfunction

  function automatic logic [7:0] m_pend();
    return (m_mode & m_pe) | (~m_mode & m_q);
  endfunction

  function automatic logic [63:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 64'(m_en);
      2'd1:    return 64'(m_mode);
      2'd2:    return 64'(m_pend());
      default: return 64'({2'(m_phase), m_rot, 3'(m_id)});
    endcase
  endfunction

  // Applies the spec's rules to the inputs about to be clocked in.
  task automatic model_edge();
    logic [7:0] cand, clr;
    cand = m_pend() & m_en;
    clr  = '0;
    if (m_phase == 0) begin
      if (cand != 0) begin
        m_id    = pick(cand, m_rot ? (m_last + 1) % 8 : 0);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.ExtIAck) begin
        clr     = 8'd1 << m_id;
        m_last  = m_id;
        m_phase = 2;
      end
    end else if (bus.eoi) begin
      m_phase = 0;
    end
    if (bus.cfg_we && bus.cfg_addr == 2'd2) clr = clr | bus.cfg_wdata[7:0];
    m_pe = ((m_pe & ~clr) | (bus.irq_in & ~m_q)) & m_mode;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        2'd0: m_en   = bus.cfg_wdata[7:0];
        2'd1: m_mode = bus.cfg_wdata[7:0];
        2'd3: m_rot  = bus.cfg_wdata[0];
        default: ;
      endcase
    end
    m_q = bus.irq_in;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r_mode, r_en;
    reset = 1'b1;
    bus.irq_in = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.ExtIAck = 1'b0; bus.eoi = 1'b0;
    step(); step();
    reset = 1'b0;

    chk_req("rst", 1'b0, 0);
    chk("rst_id", 64'(bus.irq_id), 64'd0);
    chk_rd("rst_enable", 2'd0, 64'd0);
    chk_rd("rst_mode", 2'd1, 64'd0);
    chk_rd("rst_pend", 2'd2, 64'd0);
    chk_rd("rst_ctrl", 2'd3, 64'd0);

    // register write/readback table
    vecs[0] = '{2'd0, 64'h00000000_000000A5, 64'hA5, "tbl_en_a5"};
    vecs[1] = '{2'd0, 64'hFFFFFFFF_FFFFFF00, 64'h00, "tbl_en_hi_ignored"};
    vecs[2] = '{2'd1, 64'h00000000_0000003C, 64'h3C, "tbl_mode_3c"};
    vecs[3] = '{2'd3, 64'h00000000_000000FF, 64'h08, "tbl_ctrl_rot1"};
    vecs[4] = '{2'd3, 64'h00000000_000000FE, 64'h00, "tbl_ctrl_rot0"};
    vecs[5] = '{2'd2, 64'h00000000_000000FF, 64'h00, "tbl_pend_w1c_empty"};
    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      chk_rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // single edge pulse on ch5
    wr(2'd0, 64'hFF);
    wr(2'd1, 64'hFF);
    pulse(8'h20);
    chk_req("s1_pend_edge", 1'b0, 0);
    chk_rd("s1_pend", 2'd2, 64'h20);
    step();
    chk_req("s1_req", 1'b1, 5);
    ack();
    chk_req("s1_ack", 1'b0, 0);
    chk_rd("s1_pend_after_ack", 2'd2, 64'h00);
    chk_rd("s1_ctrl_service", 2'd3, 64'h25);
    eoi_p();
    chk_rd("s1_ctrl_idle", 2'd3, 64'h05);

    // simultaneous edges, fixed priority
    pulse(8'h44);
    step();
    chk_req("s2_first", 1'b1, 2);
    ack();
    eoi_p();
    chk_req("s2_eoi_edge", 1'b0, 0);
    step();
    chk_req("s2_second", 1'b1, 6);
    ack(); eoi_p();

    // rotating priority from last-served = 3
    wr(2'd3, 64'h1);
    pulse(8'h08);
    step();
    chk_req("s3_prime", 1'b1, 3);
    ack(); eoi_p();
    pulse(8'h89);
    step();
    chk_req("s3_rot_a", 1'b1, 7);
    ack(); eoi_p(); step();
    chk_req("s3_rot_b", 1'b1, 0);
    ack(); eoi_p(); step();
    chk_req("s3_rot_c", 1'b1, 3);
    ack(); eoi_p();
    chk_rd("s3_pend_empty", 2'd2, 64'h00);

    // level channel 4
    wr(2'd3, 64'h0);
    wr(2'd1, 64'hEF);
    bus.irq_in = 8'h10;
    step();
    chk_req("s4_capture", 1'b0, 0);
    step();
    chk_req("s4_req", 1'b1, 4);
    ack();
    chk_rd("s4_pend_level_kept", 2'd2, 64'h10);
    eoi_p();
    step();
    chk_req("s4_rereq", 1'b1, 4);
    ack();
    bus.irq_in = 8'h00;
    step();
    eoi_p();
    step(); step();
    chk_req("s4_no_rereq", 1'b0, 0);
    chk_rd("s4_ctrl_idle", 2'd3, 64'h04);

    // masking during REQ, and clear/set collision
    wr(2'd1, 64'hFF);
    pulse(8'h02);
    step();
    chk_req("s5_req", 1'b1, 1);
    wr(2'd0, 64'hFD);
    chk_req("s5_masked_hold", 1'b1, 1);
    pulse(8'h01);
    chk_req("s5_higher_hold", 1'b1, 1);
    ack(); eoi_p(); step();
    chk_req("s5_next", 1'b1, 0);
    ack(); eoi_p();
    wr(2'd0, 64'h00);
    bus.irq_in = 8'h01;
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_wdata = 64'h01;
    step();
    bus.cfg_we = 1'b0; bus.irq_in = 8'h00;
    chk_rd("s5_set_wins", 2'd2, 64'h01);
    wr(2'd2, 64'h01);
    chk_rd("s5_w1c", 2'd2, 64'h00);

    // reset while in SERVICE
    wr(2'd0, 64'hFF);
    wr(2'd3, 64'h1);
    pulse(8'h10);
    step();
    chk_req("s6_req", 1'b1, 4);
    ack();
    chk_rd("s6_ctrl_service", 2'd3, 64'h2C);
    do_reset();
    chk_req("s6_after_reset", 1'b0, 0);
    chk_rd("s6_enable", 2'd0, 64'h00);
    chk_rd("s6_ctrl", 2'd3, 64'h00);
    chk_rd("s6_pend", 2'd2, 64'h00);
    step();
    chk_req("s6_stay_idle", 1'b0, 0);

    // randomized traffic against the reference model
    do_reset();
    r_mode = {32'h0, $urandom};
    r_en   = {32'h0, $urandom};
    wr(2'd1, r_mode);
    wr(2'd0, r_en);
    m_mode = r_mode[7:0]; m_en = r_en[7:0]; m_pe = '0; m_q = '0;
    m_rot = 1'b0; m_phase = 0; m_id = 0; m_last = 7;
    for (int i = 0; i < 3000; i++) begin
      bus.irq_in   = bus.irq_in ^ 8'($urandom & $urandom & $urandom);
      bus.ExtIAck  = ($urandom_range(0, 3) == 0);
      bus.eoi      = ($urandom_range(0, 4) == 0);
      bus.cfg_addr = 2'($urandom_range(0, 3));
      bus.cfg_we   = ($urandom_range(0, 15) == 0) && (bus.cfg_addr != 2'd1);
      bus.cfg_wdata = {$urandom, $urandom};
      model_edge();
      step();
      chk("rnd_extirq", 64'(bus.ExtIRQ), 64'(m_phase == 1));
      chk("rnd_id", 64'(bus.irq_id), 64'(m_id));
      chk("rnd_rdata", bus.cfg_rdata, model_rd(bus.cfg_addr));
    end
    bus.irq_in = '0; bus.cfg_we = 1'b0; bus.ExtIAck = 1'b0; bus.eoi = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
